// File: rtl/mem_access_ctrl_pkg.sv
// ============================================================================
//  Module   : mem_access_ctrl_pkg
//  Purpose  : Shared encodings for the MEM-stage data-bus access controller:
//             access-size codes, FSM state type, zero word and the alignment
//             rule used by both the controller and its lane formatter.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_ctrl_pkg;

  // Access size encodings; 2'b11 is handled as a word everywhere.
  localparam logic [1:0]  c_size_byte = 2'b00;
  localparam logic [1:0]  c_size_half = 2'b01;
  localparam logic [1:0]  c_size_word = 2'b10;

  localparam logic [31:0] c_zero_word = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_DONE  = 2'b10,
    ST_DRAIN = 2'b11
  } state_t;

  // Half accesses need an even address, word (and size 11) accesses need
  // a word-aligned address; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size == c_size_half) begin
      bad = addr_lo[0];
    end else if (size != c_size_byte) begin
      bad = (addr_lo != 2'b00);
    end
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_fmt.sv
// ============================================================================
//  Module   : mem_lane_fmt
//  Purpose  : Combinational big-endian lane formatter. Produces byte selects
//             and lane-replicated store data, and extracts/extends load data.
//  Ports    : i_addr_lo  - address bits [1:0]
//             i_size     - access size code
//             i_signed   - sign-extend load data when 1
//             i_wdata    - right-aligned store data
//             i_rdata    - raw bus read word
//             o_sel      - byte lanes, bit3 = byte 0
//             o_wdata    - replicated store data
//             o_rdata    - extracted and extended load data
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_fmt
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = 8'h00;
    w_half  = 16'h0000;
    o_sel   = 4'b0000;
    o_wdata = c_zero_word;
    o_rdata = c_zero_word;

    // Byte 0 lives in the most significant lane (big-endian bus).
    case (i_addr_lo)
      2'b00:   w_byte = i_rdata[31:24];
      2'b01:   w_byte = i_rdata[23:16];
      2'b10:   w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];

    case (i_size)
      c_size_byte: begin
        o_sel   = 4'b1000 >> i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      c_size_half: begin
        o_sel   = i_addr_lo[1] ? 4'b0011 : 4'b1100;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_signed & w_half[15]}}, w_half};
      end
      default: begin
        o_sel   = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
//  Module   : mem_access_ctrl
//  Purpose  : Sequences MEM-stage loads/stores onto a single-outstanding
//             req/ack data bus, stalls the pipeline until completion, flags
//             misaligned accesses and aborts transfers on bus timeout.
//  Ports    : clk, rst (async, active-low)
//             mem_*_i      - access request from the MEM stage
//             flush_i      - discard the current access
//             stallreq_o   - pipeline stall request
//             rdata_o / rdata_valid_o - formatted load data and its strobe
//             align_err_o / bus_err_o - exception pulses
//             bus_*        - data bus request/response
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_signed_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        align_err_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_addr;
  logic               r_we;
  logic [1:0]         r_size;
  logic               r_signed;
  logic [3:0]         r_sel;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_load_ok;

  logic               w_idle;
  logic               w_in_req;
  logic               w_in_drain;
  logic               w_align_bad;
  logic               w_start;
  logic               w_tmo;
  logic [1:0]         w_fmt_addr;
  logic [1:0]         w_fmt_size;
  logic               w_fmt_signed;
  logic [3:0]         w_fmt_sel;
  logic [31:0]        w_fmt_wdata;
  logic [31:0]        w_fmt_rdata;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_in_req    = (r_state == ST_REQ);
  assign w_in_drain  = (r_state == ST_DRAIN);
  assign w_align_bad = is_misaligned(mem_size_i, mem_addr_i[1:0]);

  // Request-driven outputs are qualified with rst so every output reads 0
  // while reset is held, even if the MEM stage is presenting a request.
  assign w_start = rst & w_idle & mem_req_i & ~flush_i & ~w_align_bad;

  // Counter holds (cycles spent in REQ/DRAIN - 1); >= also covers a DRAIN
  // entered on the very cycle the REQ limit was reached.
  assign w_tmo = (r_cnt >= CNT_W'(TIMEOUT - 1));

  // One formatter serves both directions: live inputs while launching an
  // access, latched attributes while the bus transfer is in flight.
  assign w_fmt_addr   = w_idle ? mem_addr_i[1:0] : r_addr[1:0];
  assign w_fmt_size   = w_idle ? mem_size_i      : r_size;
  assign w_fmt_signed = w_idle ? mem_signed_i    : r_signed;

  mem_lane_fmt u_fmt (
    .i_addr_lo (w_fmt_addr),
    .i_size    (w_fmt_size),
    .i_signed  (w_fmt_signed),
    .i_wdata   (mem_wdata_i),
    .i_rdata   (bus_rdata_i),
    .o_sel     (w_fmt_sel),
    .o_wdata   (w_fmt_wdata),
    .o_rdata   (w_fmt_rdata)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_REQ;
      end
      ST_REQ: begin
        // A flush coinciding with ack consumes the ack and skips DONE.
        if (bus_ack_i)    w_next = flush_i ? ST_IDLE : ST_DONE;
        else if (flush_i) w_next = ST_DRAIN;
        else if (w_tmo)   w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      ST_DRAIN: begin
        if (bus_ack_i || w_tmo) w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign align_err_o   = rst & w_idle & mem_req_i & ~flush_i & w_align_bad;
  assign stallreq_o    = w_start | w_in_req | w_in_drain;
  assign bus_req_o     = w_in_req | w_in_drain;
  assign bus_err_o     = w_in_req & ~bus_ack_i & ~flush_i & w_tmo;
  assign rdata_valid_o = (r_state == ST_DONE) & r_load_ok;
  assign rdata_o       = r_rdata;

  assign bus_we_o    = bus_req_o & r_we;
  assign bus_addr_o  = bus_req_o ? {r_addr[31:2], 2'b00} : c_zero_word;
  assign bus_sel_o   = bus_req_o ? r_sel : 4'b0000;
  assign bus_wdata_o = bus_req_o ? r_wdata : c_zero_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= c_zero_word;
      r_we      <= 1'b0;
      r_size    <= c_size_byte;
      r_signed  <= 1'b0;
      r_sel     <= 4'b0000;
      r_wdata   <= c_zero_word;
      r_rdata   <= c_zero_word;
      r_load_ok <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_in_req || w_in_drain) r_cnt <= r_cnt + CNT_W'(1);
      else                        r_cnt <= '0;

      if (w_start) begin
        r_addr    <= mem_addr_i;
        r_we      <= mem_we_i;
        r_size    <= mem_size_i;
        r_signed  <= mem_signed_i;
        r_sel     <= w_fmt_sel;
        r_wdata   <= w_fmt_wdata;
        r_load_ok <= 1'b0;
      end

      if (w_in_req) begin
        if (bus_ack_i) begin
          if (!flush_i) begin
            r_rdata   <= w_fmt_rdata;
            r_load_ok <= ~r_we;
          end
        end else if (!flush_i && w_tmo) begin
          r_rdata   <= c_zero_word;
          r_load_ok <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire
